// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin codes, coin-acceptor state encoding and item prices.
package vm_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StFull,
    StLocked
  } acc_state_e;

  localparam int unsigned DRINK_PRICE = 3;
  localparam int unsigned CHIPS_PRICE = 2;
  localparam int unsigned CHOC_PRICE  = 2;

  // Face value of a coin code; codes that carry no credit return 0.
  function automatic logic [1:0] coin_value(input logic [1:0] code);
    logic [1:0] val;
    case (code)
      COIN_1:  val = 2'd1;
      COIN_2:  val = 2'd2;
      default: val = 2'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector; RST_VAL=1 suppresses an edge for a level already high at reset.
module edge_rise #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= RST_VAL;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: converts coin strobes into a saturating registered credit for the vending FSM.
// Optional idle auto-refund is enabled by defining COIN_TIMEOUT_EN.
module coin_acceptor
  import vm_pkg::*;
#(
  parameter int unsigned MAX_CREDIT     = 7,
  parameter int unsigned CW             = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          b1,
  input  logic [1:0]    coin,
  input  logic          coin_stb,
  input  logic          lock,
  input  logic          clear,
  input  logic          refund,
  output logic [CW-1:0] amnt,
  output logic          full,
  output logic          coin_rej,
  output logic          refund_vld,
  output logic [CW-1:0] refund_amt
);

  localparam int unsigned SW    = CW + 1;
  localparam logic [CW:0] MAX_W = SW'(MAX_CREDIT);
  localparam logic [CW-1:0] MAX_N = CW'(MAX_CREDIT);

  if (MAX_CREDIT > (2 ** CW) - 1) begin : g_bad_max
    $error("MAX_CREDIT does not fit in CW bits");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be non-zero");
  end

  acc_state_e    state_q, state_d;
  logic [CW-1:0] amnt_q, amnt_d;
  logic          full_q, full_d;
  logic          rej_q, rej_d;
  logic          rvld_q, rvld_d;
  logic [CW-1:0] ramt_q, ramt_d;

  logic          stb_rise;
  logic          coin_ok;
  logic [CW:0]   sum;
  logic          credit_held;
  logic          accept;
  logic          timeout_hit;

  edge_rise #(
    .RST_VAL (1'b1)
  ) u_stb_edge (
    .clk   (clk),
    .rst_n (b1),
    .d     (coin_stb),
    .rise  (stb_rise)
  );

  assign coin_ok = (coin == COIN_1) || (coin == COIN_2);
  // CW+1 bits wide so an over-range insert can never wrap back below MAX_CREDIT.
  assign sum     = {1'b0, amnt_q} + SW'(coin_value(coin));

  assign credit_held = (state_q == StAccum) || (state_q == StFull) ||
                       ((state_q == StLocked) && (amnt_q != '0));

`ifdef COIN_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] tmr_q, tmr_d;

  assign timeout_hit = ((state_q == StAccum) || (state_q == StFull)) && (tmr_q == TMAX);

  always_comb begin
    tmr_d = tmr_q;
    if (accept || rvld_d || clear || lock || (amnt_q == '0)) begin
      tmr_d = '0;
    end else if (tmr_q != TMAX) begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge b1) begin
    if (!b1) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    amnt_d = amnt_q;
    rej_d  = 1'b0;
    rvld_d = 1'b0;
    ramt_d = '0;
    accept = 1'b0;

    if (clear) begin
      amnt_d = '0;
      rej_d  = stb_rise;
    end else if (lock) begin
      rej_d = stb_rise;
    end else if ((refund && credit_held) || timeout_hit) begin
      rvld_d = 1'b1;
      ramt_d = amnt_q;
      amnt_d = '0;
      rej_d  = stb_rise;
    end else if (stb_rise) begin
      if (coin_ok && (sum <= MAX_W)) begin
        amnt_d = sum[CW-1:0];
        accept = 1'b1;
      end else begin
        rej_d = 1'b1;
      end
    end

    if (!clear && lock) begin
      state_d = StLocked;
    end else if (amnt_d == '0) begin
      state_d = StIdle;
    end else if (amnt_d == MAX_N) begin
      state_d = StFull;
    end else begin
      state_d = StAccum;
    end

    full_d = (amnt_d == MAX_N);
  end

  always_ff @(posedge clk or negedge b1) begin
    if (!b1) begin
      state_q <= StIdle;
      amnt_q  <= '0;
      full_q  <= 1'b0;
      rej_q   <= 1'b0;
      rvld_q  <= 1'b0;
      ramt_q  <= '0;
    end else begin
      state_q <= state_d;
      amnt_q  <= amnt_d;
      full_q  <= full_d;
      rej_q   <= rej_d;
      rvld_q  <= rvld_d;
      ramt_q  <= ramt_d;
    end
  end

  assign amnt       = amnt_q;
  assign full       = full_q;
  assign coin_rej   = rej_q;
  assign refund_vld = rvld_q;
  assign refund_amt = ramt_q;

endmodule
